// File: rtl/apb3_master_arbiter.sv
// Round-robin arbiter that shares one APB3 master port among several
// requesters and decodes the address onto a set of APB3 slaves.
module apb3_master_arbiter #(
  parameter int APB_ADDR_WIDTH_P   = 16,
  parameter int APB_DATA_WIDTH_P   = 32,
  parameter int APB_NR_OF_SLAVES_P = 4,
  parameter int NR_OF_REQUESTERS_P = 2,
  parameter int TIMEOUT_CYCLES_P   = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic [NR_OF_REQUESTERS_P-1:0] req_valid,
  output logic [NR_OF_REQUESTERS_P-1:0] req_ready,
  input  logic [NR_OF_REQUESTERS_P-1:0] req_write,
  input  logic [NR_OF_REQUESTERS_P*APB_ADDR_WIDTH_P-1:0] req_addr,
  input  logic [NR_OF_REQUESTERS_P*APB_DATA_WIDTH_P-1:0] req_wdata,
  output logic [NR_OF_REQUESTERS_P-1:0] rsp_valid,
  output logic [APB_DATA_WIDTH_P-1:0] rsp_rdata,
  output logic rsp_error,
  output logic [APB_NR_OF_SLAVES_P-1:0] psel,
  output logic penable,
  output logic pwrite,
  output logic [APB_ADDR_WIDTH_P-1:0] paddr,
  output logic [APB_DATA_WIDTH_P-1:0] pwdata,
  input  logic [APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P-1:0] prdata,
  input  logic [APB_NR_OF_SLAVES_P-1:0] pready,
  input  logic [APB_NR_OF_SLAVES_P-1:0] pslverr
);

  localparam int AW = APB_ADDR_WIDTH_P;
  localparam int DW = APB_DATA_WIDTH_P;
  localparam int NS = APB_NR_OF_SLAVES_P;
  localparam int NR = NR_OF_REQUESTERS_P;
  localparam int SW = $clog2(NS);
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES_P + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic [RW-1:0] last_q;
  logic [RW-1:0] owner_q;
  logic [RW-1:0] gnt;
  logic          any;
  logic          gnt_write;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;
  logic [SW-1:0] gnt_idx;
  logic          gnt_ok;
  logic [SW-1:0] idx;
  logic [TW-1:0] cnt;
  logic          sel_ready;
  logic          sel_err;
  logic [DW-1:0] sel_rdata;
  logic          tmo;
  logic          accept;
  int            cand;

  // Search starts one past the last accepted requester and wraps.
  always_comb begin
    any       = 1'b0;
    gnt       = '0;
    gnt_write = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    cand      = 0;
    for (int k = 1; k <= NR; k++) begin
      cand = (int'(last_q) + k) % NR;
      if (!any && req_valid[cand]) begin
        any       = 1'b1;
        gnt       = RW'(cand);
        gnt_write = req_write[cand];
        gnt_addr  = req_addr[cand*AW +: AW];
        gnt_wdata = req_wdata[cand*DW +: DW];
      end
    end
  end

  assign gnt_idx = gnt_addr[AW-1 -: SW];
  assign gnt_ok  = {1'b0, gnt_idx} < (SW+1)'(NS);
  assign idx     = paddr[AW-1 -: SW];
  assign accept  = (state == IDLE) && any && !rst;

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int s = 0; s < NS; s++) begin
      if (idx == SW'(s)) begin
        sel_ready = pready[s];
        sel_err   = pslverr[s];
        sel_rdata = prdata[s*DW +: DW];
      end
    end
  end

  assign tmo = !sel_ready && (cnt == TW'(TIMEOUT_CYCLES_P));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any) state_nxt = gnt_ok ? SETUP : RESP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (sel_ready || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= RW'(NR - 1);
      owner_q   <= '0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        last_q  <= gnt;
        owner_q <= gnt;
        pwrite  <= gnt_write;
        paddr   <= gnt_addr;
        pwdata  <= gnt_wdata;
        if (!gnt_ok) begin
          rsp_rdata <= '0;
          rsp_error <= 1'b1;
        end
      end
      if (state == SETUP) cnt <= '0;
      if (state == ACCESS) begin
        cnt <= cnt + TW'(1);
        if (sel_ready) begin
          rsp_rdata <= pwrite ? '0 : sel_rdata;
          rsp_error <= sel_err;
        end else if (tmo) begin
          rsp_rdata <= '0;
          rsp_error <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    psel      = '0;
    penable   = 1'b0;
    unique case (state)
      IDLE:    if (any && !rst) req_ready[gnt] = 1'b1;
      SETUP:   for (int s = 0; s < NS; s++) psel[s] = (idx == SW'(s));
      ACCESS: begin
        for (int s = 0; s < NS; s++) psel[s] = (idx == SW'(s));
        penable = 1'b1;
      end
      RESP:    rsp_valid[owner_q] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Randomized bench for apb3_master_arbiter with a transaction-level
// model of arbitration, decode, wait states and timeout.
module tb_apb3_master_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int NR = 2;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0] rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic rsp_error;
  logic [NS-1:0] psel;
  logic penable;
  logic pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0] pready;
  logic [NS-1:0] pslverr;

  int total = 0;
  int bad = 0;
  int last;
  int refill;
  bit derr_ok;
  logic pend[NR];
  logic pw[NR];
  logic [AW-1:0] pa[NR];
  logic [DW-1:0] pd[NR];

  apb3_master_arbiter #(
    .APB_ADDR_WIDTH_P(AW),
    .APB_DATA_WIDTH_P(DW),
    .APB_NR_OF_SLAVES_P(NS),
    .NR_OF_REQUESTERS_P(NR),
    .TIMEOUT_CYCLES_P(T)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = pend[i];
      req_write[i] = pw[i];
      req_addr[i*AW +: AW] = pa[i];
      req_wdata[i*DW +: DW] = pd[i];
    end
  endtask

  task automatic junk();
    prdata  = {$urandom, $urandom, $urandom};
    pready  = 3'($urandom);
    pslverr = 3'($urandom);
  endtask

  task automatic set_req(input int i, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i] = 1'b1;
    pw[i] = w;
    pa[i] = a;
    pd[i] = d;
  endtask

  task automatic new_req(input int i);
    logic [AW-1:0] a;
    a = 16'($urandom);
    if (!derr_ok && a[15:14] == 2'b11) a[15:14] = 2'b10;
    set_req(i, 1'($urandom), a, $urandom);
  endtask

  task automatic do_refill();
    for (int i = 0; i < NR; i++)
      if (!pend[i] && (refill == 1 ||
          (refill == 2 && $urandom_range(0, 2) != 0)))
        new_req(i);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_rspv"}, rsp_valid, 0);
    check({tag, "_rdata"}, rsp_rdata, 0);
    check({tag, "_err"}, rsp_error, 0);
    check({tag, "_psel"}, psel, 0);
    check({tag, "_pen"}, penable, 0);
    check({tag, "_pwrite"}, pwrite, 0);
    check({tag, "_paddr"}, paddr, 0);
    check({tag, "_pwdata"}, pwdata, 0);
  endtask

  // One arbitration slot: w = wait states before pready, rst_at = ACCESS
  // cycle in which reset is asserted (-1 for none).
  task automatic run_one(input int w, input logic [DW-1:0] sd,
                         input logic se, input int rst_at);
    int g, n, idx;
    logic wr, ee;
    logic [AW-1:0] a;
    logic [DW-1:0] d, er;
    g = -1;
    junk();
    drive_reqs();
    for (int k = 1; k <= NR; k++)
      if (g < 0 && pend[(last + k) % NR]) g = (last + k) % NR;
    #1;
    check("idle_psel", psel, 0);
    check("idle_rspv", rsp_valid, 0);
    if (g < 0) begin
      check("idle_ready", req_ready, 0);
      step();
      return;
    end
    check("grant", req_ready, 64'(1) << g);
    last = g;
    pend[g] = 1'b0;
    wr = pw[g];
    a = pa[g];
    d = pd[g];
    idx = int'(a[15:14]);
    step();
    junk();
    if (idx >= NS) begin
      do_refill();
      drive_reqs();
      #1;
      check("derr_psel", psel, 0);
      check("derr_pen", penable, 0);
      check("derr_rspv", rsp_valid, 64'(1) << g);
      check("derr_err", rsp_error, 1);
      check("derr_rdata", rsp_rdata, 0);
      check("derr_ready", req_ready, 0);
      step();
      return;
    end
    drive_reqs();
    #1;
    check("setup_psel", psel, 64'(1) << idx);
    check("setup_pen", penable, 0);
    check("setup_paddr", paddr, a);
    check("setup_pwrite", pwrite, wr);
    check("setup_pwdata", pwdata, d);
    check("setup_ready", req_ready, 0);
    step();
    n = (w > T) ? T + 1 : w + 1;
    for (int k = 0; k < n; k++) begin
      junk();
      pready[idx] = (k == w);
      prdata[idx*DW +: DW] = sd;
      pslverr[idx] = se;
      drive_reqs();
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        drive_reqs();
        #1;
        check_reset_outs("rst_mid");
        last = NR - 1;
        step();
        return;
      end
      #1;
      check("acc_psel", psel, 64'(1) << idx);
      check("acc_pen", penable, 1);
      check("acc_paddr", paddr, a);
      check("acc_pwrite", pwrite, wr);
      check("acc_pwdata", pwdata, d);
      check("acc_rspv", rsp_valid, 0);
      check("acc_ready", req_ready, 0);
      step();
    end
    er = (w > T || wr) ? '0 : sd;
    ee = (w > T) ? 1'b1 : se;
    junk();
    do_refill();
    drive_reqs();
    #1;
    check("resp_psel", psel, 0);
    check("resp_pen", penable, 0);
    check("resp_rspv", rsp_valid, 64'(1) << g);
    check("resp_rdata", rsp_rdata, er);
    check("resp_err", rsp_error, ee);
    check("resp_paddr", paddr, a);
    check("resp_ready", req_ready, 0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    last = NR - 1;
    refill = 0;
    derr_ok = 1'b1;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      pw[i] = 1'b0;
      pa[i] = '0;
      pd[i] = '0;
    end
    drive_reqs();
    junk();
    step();
    step();
    #1;
    check_reset_outs("reset");
    step();
    rst = 1'b0;

    set_req(0, 1'b0, 16'h4010, 32'h0);
    run_one(0, 32'hDEADBEEF, 1'b0, -1);

    set_req(1, 1'b1, 16'h8000, 32'h12345678);
    run_one(3, 32'hA5A5A5A5, 1'b1, -1);

    derr_ok = 1'b0;
    refill = 1;
    new_req(0);
    new_req(1);
    for (int t = 0; t < 4; t++) run_one(0, $urandom, 1'b0, -1);
    refill = 0;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    run_one(0, 32'h0, 1'b0, -1);

    set_req(0, 1'b0, 16'hC000, 32'h0);
    run_one(0, 32'h0, 1'b0, -1);

    set_req(1, 1'b0, 16'h0004, 32'h0);
    run_one(100, 32'hFFFFFFFF, 1'b0, -1);
    run_one(0, 32'h0, 1'b0, -1);

    set_req(1, 1'b0, 16'h4000, 32'h0);
    run_one(5, 32'h11111111, 1'b0, 2);
    set_req(0, 1'b1, 16'h0100, 32'hCAFEF00D);
    set_req(1, 1'b0, 16'h4100, 32'h0);
    run_one(0, 32'h0, 1'b0, -1);
    run_one(1, 32'h87654321, 1'b0, -1);

    derr_ok = 1'b1;
    refill = 2;
    for (int t = 0; t < 250; t++)
      run_one($urandom_range(0, 11), $urandom, 1'($urandom), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
